// File: rtl/input_conditioner_pkg.sv
// Shared constants, types and helpers for the input_conditioner block.
// Holds the legal synchronizer depth range and the debounce counter sizing rule.
package input_conditioner_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;

    // A filter length of 1 or 2 still needs a 1-bit counter to stay legal.
    function automatic int debounce_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Generalised multi-bit synchronizer: STAGES flops per bit, async active-low reset.
// The last stage is the only output that may be consumed by synchronous logic.
module sync_chain
    import input_conditioner_pkg::*;
#(
    parameter int                WIDTH       = 1,
    parameter int                STAGES      = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= RESET_VALUE;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Per-channel synchronize -> debounce -> registered edge detect for raw pin inputs.
// Define INPUT_CONDITIONER_STICKY_EN to add sticky_clear/sticky_flags latched edge flags.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                   CHANNELS        = 1,
    parameter int                   STAGES          = 2,
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0]  RESET_VALUE     = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw_input,
    output logic [CHANNELS-1:0] stable_value,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
`ifdef INPUT_CONDITIONER_STICKY_EN
    ,
    input  logic [CHANNELS-1:0] sticky_clear,
    output logic [CHANNELS-1:0] sticky_flags
`endif
);

    localparam int               CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("input_conditioner: STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0] w_sync;

    sync_chain #(
        .WIDTH       (CHANNELS),
        .STAGES      (STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (raw_input),
        .o_q     (w_sync)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_stable;
        edge_t            r_edge;
        logic             w_differ;
        logic             w_accept;

        assign w_differ = (w_sync[i] != r_stable);
        // Accept only on the last of an unbroken run of disagreeing samples.
        assign w_accept = w_differ && (r_cnt == CNT_LAST);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt    <= '0;
                r_stable <= RESET_VALUE[i];
                r_edge   <= '0;
            end else begin
                r_edge.rise <= w_accept &&  w_sync[i];
                r_edge.fall <= w_accept && !w_sync[i];
                if (!w_differ || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_stable <= w_sync[i];
                end
            end
        end

        assign stable_value[i] = r_stable;
        assign rise_pulse[i]   = r_edge.rise;
        assign fall_pulse[i]   = r_edge.fall;

`ifdef INPUT_CONDITIONER_STICKY_EN
        logic r_sticky;

        // A pulse in the same cycle as a clear keeps the flag set.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sticky <= 1'b0;
            end else if (r_edge.rise || r_edge.fall) begin
                r_sticky <= 1'b1;
            end else if (sticky_clear[i]) begin
                r_sticky <= 1'b0;
            end
        end

        assign sticky_flags[i] = r_sticky;
`endif
    end

endmodule
